// File: rtl/imm_pkg.sv
// Shared format codes, FSM state type and helpers for the immediate generator stage.
package imm_pkg;

  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_I = 3'b000;
  localparam logic [FMT_W-1:0] FMT_S = 3'b001;
  localparam logic [FMT_W-1:0] FMT_B = 3'b010;
  localparam logic [FMT_W-1:0] FMT_U = 3'b011;
  localparam logic [FMT_W-1:0] FMT_J = 3'b100;
  localparam logic [FMT_W-1:0] FMT_Z = 3'b101;

  // Occupancy of the main + skid entry pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // Codes above FMT_Z are reserved
  function automatic logic fmt_legal(input logic [FMT_W-1:0] fmt);
    return (fmt <= FMT_Z);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: (instr, fmt) -> XLEN-wide extended immediate + illegal flag.
//  instr   : full 32-bit instruction word
//  fmt     : format select (I/S/B/U/J/Z, 110/111 reserved)
//  imm     : sign/zero-extended immediate, 0 for reserved codes
//  illegal : fmt is a reserved code
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]      instr,
  input  logic [FMT_W-1:0] fmt,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  // Opcode field carries no immediate bits
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = !fmt_legal(fmt);
    unique case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z: imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator with valid/ready handshake and a 2-entry skid buffer.
//  clk, rst_n (sync, active-low), flush   : clock, reset, drop all held entries
//  in_valid/in_ready, in_instr/fmt/tag    : upstream handshake and payload
//  out_valid/out_ready, out_imm/tag/illegal : downstream handshake and decoded result
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [FMT_W-1:0] in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  state_e state, state_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;

  logic accept, drain;
  logic load_main_in, load_main_skid, load_skid;

  // Decode on the input side so only the immediate is stored
  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .fmt     (in_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Next-state and entry load control
  always_comb begin
    state_d        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Redirect wins over everything, including an input accepted this cycle
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State, handshake flops and entry registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      out_imm      <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else begin
      state     <= state_d;
      out_valid <= (state_d != ST_EMPTY);
      in_ready  <= (state_d != ST_FULL);
      if (load_main_in) begin
        out_imm     <= dec_imm;
        out_tag     <= in_tag;
        out_illegal <= dec_illegal;
      end else if (load_main_skid) begin
        out_imm     <= skid_imm;
        out_tag     <= skid_tag;
        out_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_imm     <= dec_imm;
        skid_tag     <= in_tag;
        skid_illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage (XLEN=32 instance plus an XLEN=64 instance).
module tb_imm_gen_stage;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_fmt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic        out_illegal;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_instr64 = '0;
  logic [2:0]  in_fmt64 = '0;
  logic [4:0]  in_tag64 = '0;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;
  logic        out_illegal64;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag),
    .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_fmt(in_fmt64),
    .in_tag(in_tag64), .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  // Reference decode built from arithmetic shifts and masks
  function automatic exp_t model(input logic [31:0] i, input logic [2:0] f, input logic [4:0] t);
    exp_t e;
    logic signed [31:0] s;
    s = $signed(i);
    e.tag = t;
    e.ill = 1'b0;
    case (f)
      3'd0: e.imm = 32'(s >>> 20);
      3'd1: e.imm = (32'(s >>> 20) & ~32'h1F) | {27'd0, i[11:7]};
      3'd2: e.imm = (32'(s >>> 19) & 32'hFFFF_F000) | ({31'd0, i[7]} << 11)
                    | ({26'd0, i[30:25]} << 5) | ({28'd0, i[11:8]} << 1);
      3'd3: e.imm = i & 32'hFFFF_F000;
      3'd4: e.imm = (32'(s >>> 11) & 32'hFFF0_0000) | ({24'd0, i[19:12]} << 12)
                    | ({31'd0, i[20]} << 11) | ({22'd0, i[30:21]} << 1);
      3'd5: e.imm = (i >> 15) & 32'h1F;
      default: begin e.imm = '0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_fmt = 3'd0; in_tag = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_imm, out_tag, out_illegal} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b imm=%h tag=%0d ill=%b required all 0",
               out_valid, out_imm, out_tag, out_illegal);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_formats();
    logic [31:0] ins [6];
    logic [31:0] exp_imm [6];
    exp_t e;
    ins     = '{32'hFFF0_0093, 32'hFE20_AE23, 32'hFE00_0CE3, 32'h1234_50B7, 32'hFFDF_F06F, 32'h000F_D073};
    exp_imm = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h1234_5000, 32'hFFFF_FFFC, 32'h0000_001F};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_instr = ins[k]; in_fmt = 3'(k); in_tag = 5'(k + 1);
      if (in_valid && in_ready) sb.push_back('{imm: exp_imm[k], tag: 5'(k + 1), ill: 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0; in_instr = 'x; in_fmt = 'x;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fmt_latency[%0d]: got out_valid=%b required 1", k, out_valid);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL fmt_unexpected[%0d]: got output with empty scoreboard required none", k);
        end else begin
          e = sb.pop_front();
          if ({out_imm, out_tag, out_illegal} !== e) begin
            errors++;
            $display("FAIL fmt[%0d]: got imm=%h tag=%0d ill=%b required imm=%h tag=%0d ill=%b",
                     k, out_imm, out_tag, out_illegal, e.imm, e.tag, e.ill);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_instr = '0; in_fmt = '0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fmt_idle: got out_valid=%b required 0 (X inputs while idle)", out_valid);
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [2];
    logic [2:0]  fmts [2];
    logic [63:0] exp_imm [2];
    ins = '{32'h8000_00B7, 32'h000F_D073};
    fmts = '{3'd3, 3'd5};
    exp_imm = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_001F};
    for (int k = 0; k < 2; k++) begin
      in_valid64 = 1'b1; in_instr64 = ins[k]; in_fmt64 = fmts[k]; in_tag64 = 5'(20 + k);
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      checks++;
      if (out_valid64 !== 1'b1 || out_imm64 !== exp_imm[k] || out_tag64 !== 5'(20 + k)
          || out_illegal64 !== 1'b0) begin
        errors++;
        $display("FAIL xlen64[%0d]: got v=%b imm=%h tag=%0d ill=%b required v=1 imm=%h tag=%0d ill=0",
                 k, out_valid64, out_imm64, out_tag64, out_illegal64, exp_imm[k], 20 + k);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFFF_FFFF; in_fmt = 3'b110; in_tag = 5'd7;
    if (in_ready) sb.push_back(model(in_instr, in_fmt, in_tag));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!(out_valid && out_ready) || sb.size() == 0) begin
      errors++;
      $display("FAIL illegal_valid: got out_valid=%b queued=%0d required 1/1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({out_imm, out_tag, out_illegal} !== e || e != '{imm: 32'd0, tag: 5'd7, ill: 1'b1}) begin
        errors++;
        $display("FAIL illegal: got imm=%h tag=%0d ill=%b required imm=0 tag=7 ill=1",
                 out_imm, out_tag, out_illegal);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      in_valid = 1'b1; in_instr = 32'h0010_0093 * k; in_fmt = 3'd0; in_tag = 5'(k);
      if (in_ready) sb.push_back(model(in_instr, in_fmt, in_tag));
      @(posedge clk); #1;
    end
    // Third push while FULL must be refused and the head must hold
    in_tag = 5'd3; in_instr = 32'h0030_0093;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got in_ready=%b out_valid=%b out_tag=%0d required 0/1/1",
                 c, in_ready, out_valid, out_tag);
      end
      if (in_valid && in_ready) sb.push_back(model(in_instr, in_fmt, in_tag));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && out_valid === 1'b1; c++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bp_extra: got tag=%0d with empty scoreboard required none", out_tag);
      end else begin
        e = sb.pop_front();
        n++;
        if ({out_imm, out_tag, out_illegal} !== e) begin
          errors++;
          $display("FAIL bp_order: got tag=%0d imm=%h required tag=%0d imm=%h", out_tag, out_imm, e.tag, e.imm);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n != 2 || sb.size() != 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got delivered=%0d left=%0d in_ready=%b out_valid=%b required 2/0/1/0",
               n, sb.size(), in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    exp_t e;
    int   n;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 21; c++) begin
      in_valid = (c < 20);
      in_instr = $urandom; in_fmt = 3'($urandom_range(0, 5)); in_tag = 5'(c);
      if (c < 20) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready[%0d]: got in_ready=%b required 1", c, in_ready);
        end
      end
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_bubble[%0d]: got out_valid=%b required 1", c, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra[%0d]: got tag=%0d with empty scoreboard required none", c, out_tag);
        end else begin
          e = sb.pop_front();
          n++;
          if ({out_imm, out_tag, out_illegal} !== e) begin
            errors++;
            $display("FAIL stream[%0d]: got imm=%h tag=%0d ill=%b required imm=%h tag=%0d ill=%b",
                     c, out_imm, out_tag, out_illegal, e.imm, e.tag, e.ill);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_instr, in_fmt, in_tag));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 20 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_count: got delivered=%0d out_valid=%b required 20/0", n, out_valid);
    end
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'h0050_0093; in_fmt = 3'd0; in_tag = 5'(10 + k);
      if (in_ready) sb.push_back(model(in_instr, in_fmt, in_tag));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_reset();
    fill_full();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: got in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    in_valid = 1'b1; in_tag = 5'd12; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL flush[%0d]: got out_valid=%b in_ready=%b tag=%0d required 0/1",
                 c, out_valid, in_ready, out_tag);
      end
      @(posedge clk); #1;
    end
    fill_full();
    in_valid = 1'b1; in_tag = 5'd13; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({out_valid, out_imm, out_tag, out_illegal} !== 39'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset[%0d]: got v=%b imm=%h tag=%0d ill=%b in_ready=%b required 0/0/0/0/1",
                 c, out_valid, out_imm, out_tag, out_illegal, in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_illegal();
    test_backpressure();
    test_streaming();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
